// File: rtl/playback_compositor.sv
// Final VGA pixel stage: aligns sync/blank/live pixel with the ZBT playback pixel,
// switches live/playback only at frame start, and overlays border and progress bar in playback.
module playback_compositor #(
    parameter int PIPE_DELAY   = 2,
    parameter int FRAME_WIDTH  = 256,
    parameter int FRAME_HEIGHT = 192,
    parameter int NUM_FRAMES   = 20,
    parameter int BAR_STEP     = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic        one_hz_enable,
    input  logic [23:0] visualization_pixel,
    input  logic [23:0] video_pixel,
    input  logic        use_video_pixel,
    output logic [23:0] vga_out_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank,
    output logic        playback_active,
    output logic [4:0]  playback_frame
);

    typedef enum logic [1:0] {
        LIVE     = 2'd0,
        ARM      = 2'd1,
        PLAYBACK = 2'd2
    } mode_t;

    localparam logic [10:0] H_END       = 11'(FRAME_WIDTH);
    localparam logic [10:0] H_LAST      = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] H_PENULT    = 11'(FRAME_WIDTH - 2);
    localparam logic [9:0]  V_END       = 10'(FRAME_HEIGHT);
    localparam logic [9:0]  V_LAST      = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0]  V_PENULT    = 10'(FRAME_HEIGHT - 2);
    localparam logic [9:0]  BAR_TOP     = 10'(FRAME_HEIGHT + 8);
    localparam logic [9:0]  BAR_BOT     = 10'(FRAME_HEIGHT + 15);
    localparam logic [4:0]  LAST_FRAME  = 5'(NUM_FRAMES - 1);
    localparam logic [8:0]  BAR_STEP_W  = 9'(BAR_STEP);
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_GREY    = 24'h404040;

    logic [PIPE_DELAY-1:0] hs_dly, vs_dly, bl_dly;
    logic [10:0]           h_dly   [PIPE_DELAY];
    logic [9:0]            v_dly   [PIPE_DELAY];
    logic [23:0]           pix_dly [PIPE_DELAY];

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_dly <= '1;
            vs_dly <= '1;
            bl_dly <= '1;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                h_dly[i]   <= '0;
                v_dly[i]   <= '0;
                pix_dly[i] <= '0;
            end
        end else begin
            hs_dly[0]  <= hsync;
            vs_dly[0]  <= vsync;
            bl_dly[0]  <= blank;
            h_dly[0]   <= hcount;
            v_dly[0]   <= vcount;
            pix_dly[0] <= visualization_pixel;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
                bl_dly[i]  <= bl_dly[i-1];
                h_dly[i]   <= h_dly[i-1];
                v_dly[i]   <= v_dly[i-1];
                pix_dly[i] <= pix_dly[i-1];
            end
        end
    end

    logic        d_hs, d_vs, d_bl;
    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic [23:0] d_pix;
    logic        fs;

    assign d_hs  = hs_dly[PIPE_DELAY-1];
    assign d_vs  = vs_dly[PIPE_DELAY-1];
    assign d_bl  = bl_dly[PIPE_DELAY-1];
    assign d_h   = h_dly[PIPE_DELAY-1];
    assign d_v   = v_dly[PIPE_DELAY-1];
    assign d_pix = pix_dly[PIPE_DELAY-1];
    assign fs    = (d_h == 11'd0) && (d_v == 10'd0);

    mode_t      state, state_nxt;
    logic [4:0] frame, frame_nxt;
    logic       pending, pending_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LIVE;
            frame   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame   <= frame_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame;
        pending_nxt = pending;
        case (state)
            LIVE: begin
                if (use_video_pixel) state_nxt = ARM;
            end
            ARM: begin
                if (!use_video_pixel) begin
                    state_nxt = LIVE;
                end else if (fs) begin
                    state_nxt   = PLAYBACK;
                    frame_nxt   = '0;
                    pending_nxt = 1'b0;
                end
            end
            PLAYBACK: begin
                if (fs) begin
                    pending_nxt = 1'b0;
                    if (!use_video_pixel) begin
                        state_nxt = LIVE;
                    end else if (pending || one_hz_enable) begin
                        frame_nxt = (frame == LAST_FRAME) ? 5'd0 : frame + 5'd1;
                    end
                end else if (one_hz_enable) begin
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = LIVE;
        endcase
    end

    // The pixel leaving with the fs cycle already belongs to the new frame,
    // so it is composited with the post-transition mode and index.
    logic        in_h, in_v, border_col, border_row, border, bar_row, bar_fill;
    logic [8:0]  fill_len;
    logic [23:0] rgb_nxt;

    assign in_h       = d_h < H_END;
    assign in_v       = d_v < V_END;
    assign border_col = (d_h <= 11'd1) || (d_h >= H_PENULT && d_h <= H_LAST);
    assign border_row = (d_v <= 10'd1) || (d_v >= V_PENULT && d_v <= V_LAST);
    assign border     = (border_col && in_v) || (border_row && in_h);
    assign bar_row    = (d_v >= BAR_TOP) && (d_v <= BAR_BOT) && in_h;
    assign fill_len   = (9'(frame_nxt) + 9'd1) * BAR_STEP_W;
    assign bar_fill   = d_h < {2'b00, fill_len};

    always_comb begin
        rgb_nxt = '0;
        if (d_bl) begin
            rgb_nxt = '0;
        end else if (state_nxt != PLAYBACK) begin
            rgb_nxt = d_pix;
        end else if (border) begin
            rgb_nxt = RGB_RED;
        end else if (in_h && in_v) begin
            rgb_nxt = video_pixel;
        end else if (bar_row) begin
            rgb_nxt = bar_fill ? RGB_GREEN : RGB_GREY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_out_rgb <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank   <= 1'b1;
        end else begin
            vga_out_rgb <= rgb_nxt;
            vga_hsync   <= d_hs;
            vga_vsync   <= d_vs;
            vga_blank   <= d_bl;
        end
    end

    assign playback_active = (state == PLAYBACK);
    assign playback_frame  = frame;

endmodule

// File: tb/tb_playback_compositor.sv
// Randomized scoreboard bench for playback_compositor against a frame-level reference model.
module tb_playback_compositor;

    localparam int P  = 2;
    localparam int FW = 256;
    localparam int FH = 192;
    localparam int NF = 20;
    localparam int BS = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
    logic        one_hz_enable = 1'b0;
    logic [23:0] visualization_pixel = '0, video_pixel = '0;
    logic        use_video_pixel = 1'b0;
    logic [23:0] vga_out_rgb;
    logic        vga_hsync, vga_vsync, vga_blank, playback_active;
    logic [4:0]  playback_frame;

    always #5 clk = ~clk;

    playback_compositor #(
        .PIPE_DELAY(P), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
        .NUM_FRAMES(NF), .BAR_STEP(BS)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .one_hz_enable(one_hz_enable),
        .visualization_pixel(visualization_pixel), .video_pixel(video_pixel),
        .use_video_pixel(use_video_pixel), .vga_out_rgb(vga_out_rgb),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
        .playback_active(playback_active), .playback_frame(playback_frame)
    );

    typedef struct {
        int          h;
        int          v;
        bit          hs;
        bit          vs;
        bit          bl;
        logic [23:0] vis;
    } samp_t;

    // Reference state: mode 0 = live, 1 = armed, 2 = playback.
    samp_t       hist[$];
    int          m_mode = 0;
    int          m_frame = 0;
    bit          m_pend = 0;
    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic samp_t reset_samp();
        samp_t s;
        s.h = 0; s.v = 0; s.hs = 1; s.vs = 1; s.bl = 1; s.vis = '0;
        return s;
    endfunction

    function automatic logic [23:0] ref_pixel(samp_t d, int mode, int frame, logic [23:0] vid);
        bit in_h, in_v, col, row;
        in_h = d.h < FW;
        in_v = d.v < FH;
        col  = (d.h < 2) || (d.h >= FW - 2 && d.h < FW);
        row  = (d.v < 2) || (d.v >= FH - 2 && d.v < FH);
        if (d.bl) return 24'h0;
        if (mode != 2) return d.vis;
        if ((col && in_v) || (row && in_h)) return 24'hFF0000;
        if (in_h && in_v) return vid;
        if (d.v >= FH + 8 && d.v <= FH + 15 && in_h)
            return (d.h < ((frame + 1) * BS) % 512) ? 24'h00FF00 : 24'h404040;
        return 24'h0;
    endfunction

    task automatic cycle(input int h, input int v, input bit hs, input bit vs, input bit bl,
                         input logic [23:0] vis, input logic [23:0] vid,
                         input bit use_vp, input bit hz, input bit rst);
        samp_t cur, d;
        bit fs;
        logic [23:0] px;
        @(negedge clk);
        reset = rst; hcount = 11'(h); vcount = 10'(v);
        hsync = hs; vsync = vs; blank = bl;
        visualization_pixel = vis; video_pixel = vid;
        use_video_pixel = use_vp; one_hz_enable = hz;
        if (rst) begin
            hist.delete();
            repeat (P) hist.push_back(reset_samp());
            m_mode = 0; m_frame = 0; m_pend = 0;
            exp_q.push_back({24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0});
        end else begin
            cur.h = h; cur.v = v; cur.hs = hs; cur.vs = vs; cur.bl = bl; cur.vis = vis;
            d = hist.pop_front();
            hist.push_back(cur);
            fs = (d.h == 0 && d.v == 0);
            if (m_mode == 0) begin
                if (use_vp) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!use_vp) m_mode = 0;
                else if (fs) begin m_mode = 2; m_frame = 0; m_pend = 0; end
            end else begin
                if (fs) begin
                    if (!use_vp) m_mode = 0;
                    else if (m_pend || hz) m_frame = (m_frame + 1) % NF;
                    m_pend = 0;
                end else if (hz) m_pend = 1;
            end
            px = ref_pixel(d, m_mode, m_frame, vid);
            exp_q.push_back({px, d.hs, d.vs, d.bl, (m_mode == 2), 5'(m_frame)});
        end
    endtask

    task automatic rand_coord(output int h, output int v);
        int cat;
        do begin
            cat = $urandom_range(0, 5);
            case (cat)
                0: begin h = ($urandom_range(0, 1) ? FW - 2 : 0) + $urandom_range(0, 1);
                         v = $urandom_range(0, FH + 20); end
                1: begin v = ($urandom_range(0, 1) ? FH - 2 : 0) + $urandom_range(0, 1);
                         h = $urandom_range(0, FW + 10); end
                2: begin h = $urandom_range(2, FW - 3); v = $urandom_range(2, FH - 3); end
                3: begin h = $urandom_range(0, FW + 5); v = $urandom_range(FH + 6, FH + 17); end
                4: begin h = $urandom_range(0, 1343); v = $urandom_range(0, 805); end
                default: begin h = $urandom_range(0, 250); v = $urandom_range(FH + 8, FH + 15); end
            endcase
        end while (h == 0 && v == 0);
    endtask

    // One frame: (0,0) first, then random coordinates. hz_mode: 0 none, 1 mid-frame,
    // 2 coincident with the frame start reaching the aligned stage, 3 both.
    task automatic frame(input int len, input bit use_vp, input int hz_mode,
                         input int chg_at, input bit use_after, input int rst_at);
        int h, v, hz_at;
        bit u, hz;
        hz_at = $urandom_range(P + 1, len - 1);
        for (int i = 0; i < len; i++) begin
            if (i == 0) begin h = 0; v = 0; end
            else rand_coord(h, v);
            u  = (chg_at >= 0 && i >= chg_at) ? use_after : use_vp;
            hz = ((hz_mode == 1 || hz_mode == 3) && i == hz_at) ||
                 ((hz_mode == 2 || hz_mode == 3) && i == P);
            cycle(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 24'($urandom), 24'($urandom), u, hz, (i == rst_at));
        end
    endtask

    initial begin : monitor
        logic [32:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {vga_out_rgb, vga_hsync, vga_vsync, vga_blank, playback_active, playback_frame};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got rgb=%06h hs=%b vs=%b blank=%b act=%b frame=%0d, expected rgb=%06h hs=%b vs=%b blank=%b act=%b frame=%0d",
                             $time, a[32:9], a[8], a[7], a[6], a[5], a[4:0],
                             e[32:9], e[8], e[7], e[6], e[5], e[4:0]);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (P) hist.push_back(reset_samp());
        repeat (3) cycle(0, 0, 1, 1, 1, 24'h0, 24'h0, 0, 0, 1);
        for (int i = 0; i < 12; i++)
            cycle(i + 5, 30, (i % 2), 1, (i < 3), 24'h123456, 24'h0, 0, 0, 0);
        repeat (3) frame(32, 0, 0, -1, 0, -1);
        frame(32, 0, 0, 16, 1, -1);
        for (int f = 0; f < 34; f++)
            frame(28, 1, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3), -1, 0, -1);
        frame(28, 1, 1, 14, 0, -1);
        frame(28, 0, 1, -1, 0, -1);
        frame(28, 0, 0, 5, 1, -1);
        frame(28, 1, 0, 1, 0, -1);
        frame(28, 0, 0, 10, 1, -1);
        repeat (3) frame(28, 1, 1, -1, 0, -1);
        frame(28, 1, 1, 15, 1, 15);
        repeat (3) frame(28, 1, 2, -1, 0, -1);
        for (int f = 0; f < 40; f++)
            frame(24, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : -1,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 14) == 0) ? $urandom_range(0, 23) : -1);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
